// File: rtl/spi_pkg.sv
// Shared SPI definitions for the slave-side transmit and receive paths.
//   SPI_DATA_W : default transfer word width
//   SPI_CPOL/SPI_CPHA : SPI mode 0 (sclk idles low, sample on rising edge)
//   spi_state_e : transmitter state encoding
package spi_pkg;
  localparam int SPI_DATA_W = 11;
  localparam bit SPI_CPOL   = 1'b0;
  localparam bit SPI_CPHA   = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;
endpackage

// File: rtl/spi_slave_tx_if.sv
// Bundle of producer handshake and SPI pin signals for spi_slave_tx.
//   slave  modport : view of the transmitter itself
//   master modport : view of the producer / SPI master side
interface spi_slave_tx_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              cs;
  logic              sclk;
  logic              miso;
  logic              miso_oe;
  logic              tx_done;
  logic              tx_underrun;
  logic              tx_abort;

  modport slave (
    input  tx_valid, tx_data, cs, sclk,
    output tx_ready, miso, miso_oe, tx_done, tx_underrun, tx_abort
  );

  modport master (
    output tx_valid, tx_data, cs, sclk,
    input  tx_ready, miso, miso_oe, tx_done, tx_underrun, tx_abort
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin followed by a registered
// edge detector.
//   clk, rst : system clock, synchronous active-high reset
//   sig_i    : asynchronous input pin
//   rise_o   : one-cycle pulse on a synchronized 0->1 transition
//   fall_o   : one-cycle pulse on a synchronized 1->0 transition
// RST_VAL should match the pin's idle level so that leaving reset does not
// manufacture an edge.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);
  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= sig_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter. A producer loads one word into a hold
// register through a valid/ready handshake; each chip-select assertion
// shifts the held word out on MISO LSB first.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : spi_slave_tx_if.slave -- tx_valid/tx_data/tx_ready handshake,
//              cs/sclk from the master, miso/miso_oe to the pad, and the
//              tx_done/tx_underrun/tx_abort status pulses
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  spi_slave_tx_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              done_q, done_d;
  logic              under_q, under_d;
  logic              abort_q, abort_d;

  logic cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic tx_ready_w, hs;

  // cs idles high, sclk idles low
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst   (rst),
    .sig_i (bus.cs),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .sig_i (bus.sclk),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  assign tx_ready_w = !hold_vld_q && !rst;
  assign hs         = bus.tx_valid && tx_ready_w;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    done_d     = 1'b0;
    under_d    = 1'b0;
    abort_d    = 1'b0;

    if (hs) begin
      hold_d     = bus.tx_data;
      hold_vld_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          // A word arriving in this same cycle cannot be used for this
          // transfer; it stays in the hold register for the next one.
          if (hold_vld_q) begin
            shreg_d    = hold_q;
            hold_vld_d = 1'b0;
          end else begin
            shreg_d = '0;
            under_d = 1'b1;
          end
          bit_cnt_d = '0;
          oe_d      = 1'b1;
          miso_d    = shreg_d[0];
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_d == CNT_W'(DATA_W)) begin
            // Final bit sampled: completion beats a coincident cs rise.
            done_d = 1'b1;
            if (cs_rise) begin
              oe_d    = 1'b0;
              miso_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DONE;
            end
          end else if (cs_rise) begin
            abort_d = 1'b1;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (cs_rise) begin
          abort_d = 1'b1;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (sclk_fall && (bit_cnt_q < CNT_W'(DATA_W))) begin
          shreg_d = shreg_q >> 1;
          miso_d  = shreg_d[0];
        end
      end

      ST_DONE: begin
        // miso stays on the last bit; extra sclk edges are ignored
        if (cs_rise) begin
          oe_d    = 1'b0;
          miso_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_vld_q <= 1'b0;
      bit_cnt_q  <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      under_q    <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_vld_q <= hold_vld_d;
      bit_cnt_q  <= bit_cnt_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      under_q    <= under_d;
      abort_q    <= abort_d;
    end
  end

  // Data registers carry no reset; their validity is tracked by control.
  always_ff @(posedge clk) begin
    hold_q  <= hold_d;
    shreg_q <= shreg_d;
  end

  assign bus.tx_ready    = tx_ready_w;
  assign bus.miso        = miso_q;
  assign bus.miso_oe     = oe_q;
  assign bus.tx_done     = done_q;
  assign bus.tx_underrun = under_q;
  assign bus.tx_abort    = abort_q;
endmodule

// File: doc/spi_slave_tx.md
# spi_slave_tx

SPI slave-side transmitter: returns an 11-bit word to the SPI master on MISO while the master clocks a transfer with its chip-select and serial clock. It is the return path for the existing master-to-slave link. It sits beside the slave receiver on the same `cs`/`sclk` lines. It is fed by a local producer through a valid/ready handshake and holds one word in reserve so back-to-back transfers need no idle gap.

## Interface
Parameters:
- `DATA_W`, 11, transfer word width in bits.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_valid`  in  1  producer has a word on `tx_data`.
- `tx_data`  in  DATA_W  word to transmit, LSB first.
- `tx_ready`  out  1  hold register is empty; the word is accepted when `tx_valid && tx_ready`.
- `cs`  in  1  chip select from the master, active low, asynchronous to `clk`.
- `sclk`  in  1  SPI clock from the master, asynchronous to `clk`, idles low.
- `miso`  out  1  serial data to the master.
- `miso_oe`  out  1  output enable for the `miso` pad; 1 only while selected.
- `tx_done`  out  1  one-cycle pulse when a full word has been shifted out.
- `tx_underrun`  out  1  one-cycle pulse when `cs` falls with no word held.
- `tx_abort`  out  1  one-cycle pulse when `cs` rises mid-word.

## Operation
- SPI mode 0 (CPOL=0, CPHA=0):
  - The master samples `miso` on rising `sclk`.
  - This block changes `miso` after falling `sclk`.
- Data is sent LSB first.
- `cs` and `sclk` each pass through a 2-flop synchronizer plus a registered edge detector. All protocol decisions use the synchronized edges.
- Hold register (`hold_q`, `hold_vld`):
  - Filled on handshake.
  - `tx_ready = !hold_vld` while `rst` is low; `tx_ready` is forced to 0 while `rst` is high.
  - Emptied only when a transfer starts.
- State machine with states IDLE, SHIFT, DONE:
  - **IDLE**, on `cs` falling:
    - Shift register ← `hold_q`, or all zeros if `!hold_vld`; in the zero case pulse `tx_underrun`.
    - Clear `hold_vld`, `bit_cnt` ← 0, `miso_oe` ← 1, `miso` ← bit 0.
    - Go to SHIFT.
  - **SHIFT**, on `sclk` rising: `bit_cnt` increments. When it reaches DATA_W, pulse `tx_done` and go to DONE.
  - **SHIFT**, on `sclk` falling with `bit_cnt` < DATA_W: shift right and present the next bit on `miso`.
  - **SHIFT**, on `cs` rising before `tx_done`: pulse `tx_abort`, `miso_oe` ← 0, go to IDLE. The word is discarded, not requeued.
  - **DONE**: `miso` holds the last bit and further `sclk` edges are ignored. On `cs` rising: `miso_oe` ← 0, go to IDLE.
- A handshake may occur in any state. A word loaded during SHIFT or DONE is used by the next `cs` fall.
- `bit_cnt` is $clog2(DATA_W+1) bits wide and does not wrap.
- Simultaneous events:
  - Handshake and `cs` fall in the same cycle while `!hold_vld`: the transfer uses zeros with `tx_underrun`, and the new word stays held.
  - `cs` rise coincident with the final `sclk` rise: `tx_done` wins, no `tx_abort`, go straight to IDLE.

## Timing
- Reset values: state IDLE, `miso` 0, `miso_oe` 0, `tx_done`/`tx_underrun`/`tx_abort` 0, `hold_vld` 0. `tx_ready` reads 1 on the first cycle after `rst` deasserts.
- Pin-to-action latency is 3 `clk` cycles (2 sync + 1 edge register):
  - `miso`/`miso_oe` update 3 cycles after `cs` falls.
  - The next bit appears 3 cycles after `sclk` falls.
- `tx_done` is asserted 3 cycles after the DATA_W-th `sclk` rise.
- Constraints on the master:
  - `sclk` high and low phases are each ≥ 4 `clk` periods.
  - First `sclk` rise comes ≥ 4 `clk` after `cs` falls.
  - `cs` stays high ≥ 4 `clk` between words.
- `rst` asserted mid-transfer: the block returns to its reset values on the next edge, and the held word is lost.

## Structure
- Shared package `spi_pkg`:
  - State encoding (IDLE/SHIFT/DONE).
  - `SPI_DATA_W` = 11.
  - Mode constants `SPI_CPOL` = 0, `SPI_CPHA` = 0.
- Sub-module `spi_sync_edge`: 2-flop synchronizer plus rise/fall pulse outputs, instantiated for `cs` and `sclk`. The slave receiver reuses it.

## Test plan
- Load 11'h5A3 via handshake, drive a transfer at `clk`/8 → master samples 11'h5A3 LSB-first, one `tx_done` pulse, `miso_oe` drops 3 cycles after `cs` rises.
- Two back-to-back transfers: 11'h001 loaded, then 11'h7FF loaded during the first transfer → `tx_ready` low until the second `cs` fall, master receives 11'h001 then 11'h7FF.
- `cs` falls with no word loaded → `tx_underrun` pulse, master receives 11'h000, `tx_ready` remains 1.
- `cs` rises after 5 `sclk` rises of 11'h2AA → `tx_abort` pulse, no `tx_done`, `miso_oe` 0, next transfer with an empty hold register underruns.
- `rst` asserted at bit 6 with a second word held → all outputs at reset values next cycle, `tx_ready` 1, next transfer underruns.
- 3 extra `sclk` pulses after 11 bits, before `cs` rises → `miso` frozen at bit 10, single `tx_done`.
